// File: rtl/mac_tx_framer_if.sv
// Byte-stream interface between the host packet buffer, the framer and the
// RGMII transmit stage. The host side drives s_*; the framer drives s_ready
// and the line-side byte/control pair.
interface mac_tx_framer_if;
    logic [7:0] s_data;
    logic       s_valid;
    logic       s_last;
    logic       s_ready;
    logic [7:0] mac_txd;
    logic       phy_tx_ctl;

    modport master (
        output s_data, s_valid, s_last,
        input  s_ready, mac_txd, phy_tx_ctl
    );

    modport slave (
        input  s_data, s_valid, s_last,
        output s_ready, mac_txd, phy_tx_ctl
    );
endinterface

// File: rtl/mac_tx_framer.sv
// Ethernet transmit framer: preamble/SFD insertion, padding to the minimum
// frame size, CRC-32 FCS append and inter-frame gap enforcement. Payload bytes
// pass straight through with one register stage; the line cannot stall, so a
// missing byte mid-payload aborts the frame and the rest of it is discarded.
module mac_tx_framer #(
    parameter int MIN_LEN      = 60,
    parameter int IFG_LEN      = 12,
    parameter int PREAMBLE_LEN = 7
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            config_ready,
    output logic            tx_busy,
    output logic            tx_underrun,
    mac_tx_framer_if.slave  bus
);

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_PREAMBLE = 3'd1;
    localparam logic [2:0] S_SFD      = 3'd2;
    localparam logic [2:0] S_PAYLOAD  = 3'd3;
    localparam logic [2:0] S_PAD      = 3'd4;
    localparam logic [2:0] S_FCS      = 3'd5;
    localparam logic [2:0] S_DROP     = 3'd6;
    localparam logic [2:0] S_IFG      = 3'd7;

    localparam logic [5:0] L_MIN      = 6'(MIN_LEN);
    localparam logic [3:0] L_PRE_LAST = 4'(PREAMBLE_LEN - 1);
    localparam logic [3:0] L_IFG_LAST = 4'(IFG_LEN - 1);
    localparam logic [3:0] L_FCS_LAST = 4'd3;

    // One byte of reflected CRC-32 (poly 0xEDB88320), LSB first.
    function automatic logic [31:0] f_crc_byte(input logic [31:0] c_in,
                                               input logic [7:0]  d);
        logic [31:0] c;
        c = c_in ^ {24'h0, d};
        for (int b = 0; b < 8; b++) begin
            c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
        end
        return c;
    endfunction

    logic [2:0]  r_state;
    logic [3:0]  r_cnt;     // shared by preamble, FCS byte index and IFG
    logic [5:0]  r_len;     // payload+pad length, saturates at MIN_LEN
    logic [31:0] r_crc;
    logic [7:0]  r_txd;
    logic        r_ctl;
    logic        r_und;

    logic [2:0]  w_state_nxt;
    logic [3:0]  w_cnt_nxt;
    logic [5:0]  w_len_nxt;
    logic [5:0]  w_len_inc;
    logic [31:0] w_crc_nxt;
    logic [31:0] w_crc_inv;
    logic [7:0]  w_fcs_byte;
    logic [7:0]  w_txd_nxt;
    logic        w_ctl_nxt;
    logic        w_und_nxt;

    // Ready depends on the state register alone so upstream never sees a
    // combinational path from its own valid.
    assign bus.s_ready    = (r_state == S_PAYLOAD) || (r_state == S_DROP);
    assign bus.mac_txd    = r_txd;
    assign bus.phy_tx_ctl = r_ctl;
    assign tx_busy        = (r_state != S_IDLE);
    assign tx_underrun    = r_und;

    assign w_len_inc = (r_len >= L_MIN) ? L_MIN : (r_len + 6'd1);
    assign w_crc_inv = ~r_crc;

    // Select the FCS byte for the current index, least-significant first.
    always_comb begin
        w_fcs_byte = w_crc_inv[7:0];
        case (r_cnt[1:0])
            2'd0: w_fcs_byte = w_crc_inv[7:0];
            2'd1: w_fcs_byte = w_crc_inv[15:8];
            2'd2: w_fcs_byte = w_crc_inv[23:16];
            2'd3: w_fcs_byte = w_crc_inv[31:24];
            default: w_fcs_byte = w_crc_inv[7:0];
        endcase
    end

    // Next-state, counter, CRC and next output byte decisions.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_len_nxt   = r_len;
        w_crc_nxt   = r_crc;
        w_txd_nxt   = 8'h00;
        w_ctl_nxt   = 1'b0;
        w_und_nxt   = 1'b0;
        case (r_state)
            S_IDLE: begin
                // Nothing is consumed here; the first byte waits for PAYLOAD.
                if (config_ready && bus.s_valid) begin
                    w_state_nxt = S_PREAMBLE;
                    w_cnt_nxt   = 4'd0;
                end
            end
            S_PREAMBLE: begin
                w_txd_nxt = 8'h55;
                w_ctl_nxt = 1'b1;
                if (r_cnt == L_PRE_LAST) begin
                    w_state_nxt = S_SFD;
                    w_cnt_nxt   = 4'd0;
                    w_crc_nxt   = 32'hFFFF_FFFF;
                end else begin
                    w_cnt_nxt = r_cnt + 4'd1;
                end
            end
            S_SFD: begin
                w_txd_nxt   = 8'hD5;
                w_ctl_nxt   = 1'b1;
                w_len_nxt   = 6'd0;
                w_state_nxt = S_PAYLOAD;
            end
            S_PAYLOAD: begin
                if (bus.s_valid) begin
                    w_txd_nxt = bus.s_data;
                    w_ctl_nxt = 1'b1;
                    w_crc_nxt = f_crc_byte(r_crc, bus.s_data);
                    w_len_nxt = w_len_inc;
                    if (bus.s_last) begin
                        w_state_nxt = (w_len_inc < L_MIN) ? S_PAD : S_FCS;
                        w_cnt_nxt   = 4'd0;
                    end
                end else begin
                    // Starved mid-frame: abort, the FCS is never sent.
                    w_und_nxt   = 1'b1;
                    w_state_nxt = S_DROP;
                end
            end
            S_PAD: begin
                w_ctl_nxt = 1'b1;
                w_crc_nxt = f_crc_byte(r_crc, 8'h00);
                w_len_nxt = w_len_inc;
                if (w_len_inc == L_MIN) begin
                    w_state_nxt = S_FCS;
                    w_cnt_nxt   = 4'd0;
                end
            end
            S_FCS: begin
                w_txd_nxt = w_fcs_byte;
                w_ctl_nxt = 1'b1;
                if (r_cnt == L_FCS_LAST) begin
                    w_state_nxt = S_IFG;
                    w_cnt_nxt   = 4'd0;
                end else begin
                    w_cnt_nxt = r_cnt + 4'd1;
                end
            end
            S_DROP: begin
                if (bus.s_valid && bus.s_last) begin
                    w_state_nxt = S_IFG;
                    w_cnt_nxt   = 4'd0;
                end
            end
            S_IFG: begin
                if (r_cnt == L_IFG_LAST) begin
                    w_state_nxt = S_IDLE;
                    w_cnt_nxt   = 4'd0;
                end else begin
                    w_cnt_nxt = r_cnt + 4'd1;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_cnt_nxt   = 4'd0;
            end
        endcase
    end

    // State, counters, CRC and the registered line outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
            r_cnt   <= 4'd0;
            r_len   <= 6'd0;
            r_crc   <= 32'hFFFF_FFFF;
            r_txd   <= 8'h00;
            r_ctl   <= 1'b0;
            r_und   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_len   <= w_len_nxt;
            r_crc   <= w_crc_nxt;
            r_txd   <= w_txd_nxt;
            r_ctl   <= w_ctl_nxt;
            r_und   <= w_und_nxt;
        end
    end

endmodule

// File: tb/tb_mac_tx_framer.sv
// Scoreboard bench for mac_tx_framer: stimulus pushes expected line bytes and
// frame lengths; a negedge monitor pops and compares whatever the DUT emits.
module tb_mac_tx_framer;
    localparam int MIN_LEN = 60;

    typedef struct {
        int len;
        bit crc;
    } fr_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic config_ready = 1'b0;
    logic tx_busy;
    logic tx_underrun;

    mac_tx_framer_if bus();

    mac_tx_framer #(.MIN_LEN(60), .IFG_LEN(12), .PREAMBLE_LEN(7)) dut (
        .clk(clk),
        .rst(rst),
        .config_ready(config_ready),
        .tx_busy(tx_busy),
        .tx_underrun(tx_underrun),
        .bus(bus)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    logic [7:0] exp_q[$];
    fr_t        len_q[$];
    logic [7:0] pl[$];
    logic [7:0] fb[$];
    int n_underrun = 0;
    int n_ready = 0;
    int last_gap = 0;
    int gap = 0;
    int run = 0;
    bit in_frame = 0;

    function automatic logic [31:0] crc8(input logic [31:0] c_in, input logic [7:0] d);
        logic [31:0] c;
        c = c_in ^ {24'h0, d};
        for (int b = 0; b < 8; b++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
        return c;
    endfunction

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", nm, got, exp);
        end
    endtask

    // Expected preamble, SFD, payload, pad and FCS for the frame in pl.
    task automatic push_full();
        logic [31:0] c;
        fr_t f;
        int n;
        n = pl.size();
        c = 32'hFFFF_FFFF;
        repeat (7) exp_q.push_back(8'h55);
        exp_q.push_back(8'hD5);
        for (int i = 0; i < n; i++) begin
            exp_q.push_back(pl[i]);
            c = crc8(c, pl[i]);
        end
        for (int i = n; i < MIN_LEN; i++) begin
            exp_q.push_back(8'h00);
            c = crc8(c, 8'h00);
        end
        c = ~c;
        for (int k = 0; k < 4; k++) exp_q.push_back(c[8*k +: 8]);
        f.len = 8 + ((n > MIN_LEN) ? n : MIN_LEN) + 4;
        f.crc = 1'b1;
        len_q.push_back(f);
    endtask

    // Offer pl byte by byte; optionally starve once or assert reset mid-frame.
    task automatic drive(input int drop_at, input int rst_at);
        int idx;
        int guard;
        bit dropped;
        idx = 0;
        guard = 0;
        dropped = 0;
        while (idx < pl.size()) begin
            @(negedge clk);
            guard++;
            if (guard > 3000) begin
                chk("drive_timeout", 32'd1, 32'd0);
                return;
            end
            if (idx == rst_at) begin
                #2 rst = 1'b0;
                #1;
                chk("rst_mid_ctl", {31'd0, bus.phy_tx_ctl}, 32'd0);
                chk("rst_mid_txd", {24'd0, bus.mac_txd}, 32'd0);
                chk("rst_mid_busy", {31'd0, tx_busy}, 32'd0);
                chk("rst_mid_ready", {31'd0, bus.s_ready}, 32'd0);
                bus.s_valid = 1'b0;
                bus.s_last  = 1'b0;
                return;
            end
            bus.s_data = pl[idx];
            bus.s_last = (idx == pl.size() - 1);
            if (idx == drop_at && !dropped) begin
                bus.s_valid = 1'b0;
                dropped = 1;
            end else begin
                bus.s_valid = 1'b1;
            end
            #1;
            if (bus.s_ready && bus.s_valid) idx++;
        end
    endtask

    task automatic idle_inputs();
        @(negedge clk);
        bus.s_valid = 1'b0;
        bus.s_last  = 1'b0;
    endtask

    task automatic drain();
        int g;
        g = 0;
        while ((exp_q.size() != 0 || len_q.size() != 0) && g < 3000) begin
            @(negedge clk);
            g++;
        end
        if (g >= 3000) chk("drain_timeout", 32'd1, 32'd0);
        repeat (16) @(negedge clk);
    endtask

    // Monitor: compare every emitted byte and every completed frame.
    always @(negedge clk) begin
        if (!rst) begin
            in_frame = 0;
            run = 0;
            gap = 0;
            fb.delete();
        end else begin
            if (tx_underrun) n_underrun++;
            if (bus.s_ready) n_ready++;
            if (bus.phy_tx_ctl) begin
                if (!in_frame) begin
                    last_gap = gap;
                    in_frame = 1;
                    run = 0;
                    fb.delete();
                end
                run++;
                fb.push_back(bus.mac_txd);
                if (exp_q.size() == 0) chk("unexpected_byte", {24'd0, bus.mac_txd}, 32'hFFFF_FFFF);
                else chk("line_byte", {24'd0, bus.mac_txd}, {24'd0, exp_q.pop_front()});
            end else begin
                if (in_frame) begin
                    fr_t f;
                    logic [31:0] c;
                    in_frame = 0;
                    gap = 0;
                    if (len_q.size() == 0) chk("unexpected_frame", 32'd1, 32'd0);
                    else begin
                        f = len_q.pop_front();
                        chk("frame_len", run, f.len);
                        if (f.crc) begin
                            c = 32'hFFFF_FFFF;
                            for (int i = 8; i < fb.size(); i++) c = crc8(c, fb[i]);
                            chk("fcs_residue", c, 32'hDEBB20E3);
                        end
                    end
                end
                gap++;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int r0;
        int u0;
        fr_t f;
        bus.s_data  = 8'h00;
        bus.s_valid = 1'b0;
        bus.s_last  = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_txd", {24'd0, bus.mac_txd}, 32'd0);
        chk("reset_ctl", {31'd0, bus.phy_tx_ctl}, 32'd0);
        chk("reset_ready", {31'd0, bus.s_ready}, 32'd0);
        chk("reset_busy", {31'd0, tx_busy}, 32'd0);
        chk("reset_underrun", {31'd0, tx_underrun}, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        config_ready = 1'b1;

        // 60-byte payload, no pad
        pl.delete();
        for (int i = 0; i < 60; i++) pl.push_back(8'(i));
        push_full();
        drive(-1, -1);
        idle_inputs();
        drain();

        // 1-byte payload padded to the minimum
        pl.delete();
        pl.push_back(8'hAB);
        r0 = n_ready;
        push_full();
        drive(-1, -1);
        idle_inputs();
        drain();
        chk("ready_cycles_1byte", n_ready - r0, 32'd1);

        // two 100-byte frames back to back
        pl.delete();
        for (int i = 0; i < 100; i++) pl.push_back(8'(i * 3 + 1));
        push_full();
        drive(-1, -1);
        push_full();
        drive(-1, -1);
        idle_inputs();
        drain();
        chk("b2b_idle_gap", last_gap, 32'd13);

        // underrun after 20 bytes, s_last at byte 40, next frame right after
        u0 = n_underrun;
        pl.delete();
        for (int i = 0; i < 40; i++) pl.push_back(8'(8'h80 + i));
        repeat (7) exp_q.push_back(8'h55);
        exp_q.push_back(8'hD5);
        for (int i = 0; i < 20; i++) exp_q.push_back(pl[i]);
        f.len = 28;
        f.crc = 1'b0;
        len_q.push_back(f);
        drive(20, -1);
        pl.delete();
        for (int i = 0; i < 10; i++) pl.push_back(8'(8'hF0 - i));
        push_full();
        drive(-1, -1);
        idle_inputs();
        drain();
        chk("underrun_pulses", n_underrun - u0, 32'd1);
        chk("underrun_gap", last_gap, 32'd34);

        // config_ready held low: nothing may start
        pl.delete();
        for (int i = 0; i < 5; i++) pl.push_back(8'(8'h30 + i));
        @(negedge clk);
        config_ready = 1'b0;
        bus.s_data  = pl[0];
        bus.s_last  = 1'b0;
        bus.s_valid = 1'b1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            chk("cfg_hold", {29'd0, bus.phy_tx_ctl, bus.s_ready, tx_busy}, 32'd0);
        end
        push_full();
        config_ready = 1'b1;
        @(negedge clk);
        chk("cfg_start_k1", {31'd0, bus.phy_tx_ctl}, 32'd0);
        @(negedge clk);
        chk("cfg_start_k2_ctl", {31'd0, bus.phy_tx_ctl}, 32'd1);
        chk("cfg_start_k2_txd", {24'd0, bus.mac_txd}, 32'h55);
        drive(-1, -1);
        idle_inputs();
        drain();

        // reset during payload byte 30, then a fresh saturating-length frame
        u0 = n_underrun;
        pl.delete();
        for (int i = 0; i < 50; i++) pl.push_back(8'(8'h11 * i));
        push_full();
        drive(-1, 30);
        exp_q.delete();
        len_q.delete();
        repeat (3) @(negedge clk);
        rst = 1'b1;
        chk("rst_no_underrun", n_underrun - u0, 32'd0);
        pl.delete();
        for (int i = 0; i < 64; i++) pl.push_back(8'(8'hC3 ^ i));
        push_full();
        drive(-1, -1);
        idle_inputs();
        drain();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
